// File: rtl/pam4_prbs_tx_mapper.sv
// PRBS-7 driven PAM4 transmit symbol source with a valid/ready output stage.
// Optional macro PAM4_GRAY_CODING_EN selects the Gray level map (natural binary otherwise).
module pam4_prbs_tx_mapper #(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 56,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                start,
  input  logic                                stop,
  input  logic [6:0]                          seed,
  input  logic [COUNT_WIDTH-1:0]              num_symbols,
  input  logic                                tx_ready,
  output logic                                tx_valid,
  output logic signed [SIGNAL_RESOLUTION-1:0] tx_symbol,
  output logic [1:0]                          tx_bits,
  output logic                                busy,
  output logic                                done,
  output logic [COUNT_WIDTH-1:0]              sym_count,
  output logic [1:0]                          state_dbg
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic signed [SIGNAL_RESOLUTION-1:0] LVL_P1 =
    SIGNAL_RESOLUTION'(SYMBOL_SEPERATION / 2);
  localparam logic signed [SIGNAL_RESOLUTION-1:0] LVL_P3 =
    SIGNAL_RESOLUTION'(3 * SYMBOL_SEPERATION / 2);

  state_t                 state;
  logic [6:0]             lfsr;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   counted;

  logic       b1;
  logic       b2;
  logic [6:0] lfsr_s1;
  logic [6:0] lfsr_s2;
  logic       load;
  logic       handshake;

  // Two Fibonacci steps of x^7+x^6+1 per symbol; b1 is the earlier bit.
  assign b1      = lfsr[6] ^ lfsr[5];
  assign lfsr_s1 = {lfsr[5:0], b1};
  assign b2      = lfsr_s1[6] ^ lfsr_s1[5];
  assign lfsr_s2 = {lfsr_s1[5:0], b2};

  // Handshake: a symbol transfers on any cycle with tx_valid && tx_ready. While
  // tx_valid is high and tx_ready low the output register holds, and tx_valid
  // only falls after a transfer. A new symbol loads when the register is empty
  // or being emptied in the same cycle.
  assign handshake = tx_valid && tx_ready;
  assign load      = (state == RUN) && (!tx_valid || tx_ready);

  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign state_dbg = state;

  function automatic logic signed [SIGNAL_RESOLUTION-1:0] map_level(input logic [1:0] bits);
    logic [1:0] idx;
`ifdef PAM4_GRAY_CODING_EN
    idx = {bits[1], bits[1] ^ bits[0]};
`else
    idx = bits;
`endif
    case (idx)
      2'b00:   map_level = -LVL_P3;
      2'b01:   map_level = -LVL_P1;
      2'b10:   map_level = LVL_P1;
      default: map_level = LVL_P3;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      lfsr      <= 7'h01;
      remaining <= '0;
      counted   <= 1'b0;
      tx_valid  <= 1'b0;
      tx_symbol <= '0;
      tx_bits   <= '0;
      sym_count <= '0;
    end else begin
      if (handshake && (sym_count != '1)) begin
        sym_count <= sym_count + 1'b1;
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            lfsr      <= (seed == 7'h00) ? 7'h01 : seed;
            remaining <= num_symbols;
            counted   <= (num_symbols != '0);
            sym_count <= '0;
          end
        end
        RUN: begin
          if (load) begin
            tx_valid  <= 1'b1;
            tx_bits   <= {b1, b2};
            tx_symbol <= map_level({b1, b2});
            lfsr      <= lfsr_s2;
            if (counted) begin
              remaining <= remaining - 1'b1;
            end
          end
          // A stop coinciding with a load still lets that symbol go out via DRAIN.
          if (stop || (load && counted && (remaining == COUNT_WIDTH'(1)))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!tx_valid || tx_ready) begin
            tx_valid <= 1'b0;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pam4_prbs_tx_mapper.sv
// Randomized bench for pam4_prbs_tx_mapper: PRBS recurrence model, scoreboard and directed cases.
module tb_pam4_prbs_tx_mapper;

  localparam int SR = 8;
  localparam int S  = 56;
  localparam int CW = 16;

  logic                 clk;
  logic                 rstn;
  logic                 start;
  logic                 stop;
  logic [6:0]           seed;
  logic [CW-1:0]        num_symbols;
  logic                 tx_ready;
  logic                 tx_valid;
  logic signed [SR-1:0] tx_symbol;
  logic [1:0]           tx_bits;
  logic                 busy;
  logic                 done;
  logic [CW-1:0]        sym_count;
  logic [1:0]           state_dbg;

  int vectors     = 0;
  int miscompares = 0;
  int accept_cnt  = 0;
  int ready_mode  = 0;
  logic ready_manual = 1'b1;

  logic [1:0] exp_q[$];

  pam4_prbs_tx_mapper #(
    .SIGNAL_RESOLUTION(SR),
    .SYMBOL_SEPERATION(S),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .seed(seed),
    .num_symbols(num_symbols), .tx_ready(tx_ready), .tx_valid(tx_valid),
    .tx_symbol(tx_symbol), .tx_bits(tx_bits), .busy(busy), .done(done),
    .sym_count(sym_count), .state_dbg(state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: PRBS-7 as the recurrence s[k] = s[k-7] ^ s[k-6], seed bits oldest first.
  task automatic load_expected(input logic [6:0] sd, input int nsym);
    bit s[$];
    logic [6:0] sv;
    exp_q.delete();
    sv = (sd == 7'h00) ? 7'h01 : sd;
    for (int i = 0; i < 7; i++) s.push_back(sv[6-i]);
    for (int k = 7; k < 7 + 2 * nsym; k++) s.push_back(s[k-7] ^ s[k-6]);
    for (int j = 0; j < nsym; j++) exp_q.push_back({s[7+2*j], s[8+2*j]});
  endtask

  function automatic int exp_level(input logic [1:0] b);
    int idx;
`ifdef PAM4_GRAY_CODING_EN
    idx = (b[1] ? 2 : 0) + ((b[1] ^ b[0]) ? 1 : 0);
`else
    idx = int'(b);
`endif
    return (2 * idx - 3) * S / 2;
  endfunction

  // Ready driver: 0 = always ready, 1 = random, 2 = ready_manual
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = ready_manual;
      endcase
    end
  end

  // Scoreboard monitor: checks every handshake and output stability under backpressure
  initial begin
    logic hold_prev;
    logic [1:0] prev_bits;
    logic signed [SR-1:0] prev_sym;
    logic [1:0] e;
    hold_prev = 1'b0;
    prev_bits = '0;
    prev_sym  = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          check("hold_valid", 32'(tx_valid), 1);
          check("hold_bits", 32'(tx_bits), 32'(prev_bits));
          check("hold_sym", tx_symbol, prev_sym);
        end
        if (tx_valid && tx_ready) begin
          check("sb_nonempty", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_bits", 32'(tx_bits), 32'(e));
            check("sb_sym", tx_symbol, exp_level(e));
          end
          accept_cnt++;
        end
        hold_prev = tx_valid && !tx_ready;
        prev_bits = tx_bits;
        prev_sym  = tx_symbol;
      end
    end
  end

  // Driver tasks
  task automatic start_run(input logic [6:0] sd, input int n, input int qlen);
    load_expected(sd, qlen);
    accept_cnt = 0;
    @(posedge clk);
    #1;
    seed        = sd;
    num_symbols = CW'(n);
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    check(tag, 32'(done), 1);
  endtask

  initial begin
    logic [1:0] hb;
    logic signed [SR-1:0] hs;
    logic [1:0] d_bits[4];
    int d_sym[4];
    int n;

    rstn = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    seed = '0;
    num_symbols = '0;
    ready_mode = 0;

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rst_valid", 32'(tx_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sym", tx_symbol, 0);
    check("rst_bits", 32'(tx_bits), 0);
    check("rst_count", 32'(sym_count), 0);

    // Directed: seed 7F, four symbols, always ready
    d_bits[0] = 2'b00; d_bits[1] = 2'b00; d_bits[2] = 2'b00; d_bits[3] = 2'b10;
    d_sym[0] = -84; d_sym[1] = -84; d_sym[2] = -84;
`ifdef PAM4_GRAY_CODING_EN
    d_sym[3] = 84;
`else
    d_sym[3] = 28;
`endif
    start_run(7'h7F, 4, 4);
    check("lat_not_yet", 32'(tx_valid), 0);
    check("lat_busy", 32'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("dir_valid", 32'(tx_valid), 1);
      check("dir_bits", 32'(tx_bits), 32'(d_bits[i]));
      check("dir_sym", tx_symbol, d_sym[i]);
      check("dir_done_low", 32'(done), 0);
    end
    @(posedge clk);
    #1;
    check("dir_done", 32'(done), 1);
    check("dir_busy", 32'(busy), 0);
    check("dir_valid_off", 32'(tx_valid), 0);
    check("dir_count", 32'(sym_count), 4);
    check("dir_sb_empty", exp_q.size(), 0);

    // Randomized counted runs with random backpressure, restarting from DONE
    ready_mode = 1;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 40);
      start_run(7'($urandom_range(0, 127)), n, n);
      wait_done("rnd_done");
      check("rnd_count", 32'(sym_count), n);
      check("rnd_sb_empty", exp_q.size(), 0);
      check("rnd_busy", 32'(busy), 0);
    end

    // Backpressure window: five stalled cycles mid-run
    ready_mode = 0;
    start_run(7'($urandom_range(1, 127)), 30, 30);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (accept_cnt >= 10) break;
    end
    check("bp_reached", 32'(accept_cnt >= 10), 1);
    ready_manual = 1'b0;
    ready_mode = 2;
    hb = tx_bits;
    hs = tx_symbol;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_valid", 32'(tx_valid), 1);
      check("bp_bits", 32'(tx_bits), 32'(hb));
      check("bp_sym", tx_symbol, hs);
    end
    ready_mode = 0;
    wait_done("bp_done");
    check("bp_count", 32'(sym_count), 30);
    check("bp_sb_empty", exp_q.size(), 0);

    // Continuous run stopped after 20 accepts while stalled
    ready_manual = 1'b1;
    ready_mode = 2;
    start_run(7'($urandom_range(1, 127)), 0, 300);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (accept_cnt == 20) break;
    end
    check("stop_reached", accept_cnt, 20);
    ready_manual = 1'b0;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    repeat (3) begin
      check("stop_held_valid", 32'(tx_valid), 1);
      check("stop_not_done", 32'(done), 0);
      @(posedge clk);
      #1;
    end
    ready_manual = 1'b1;
    @(posedge clk);
    #1;
    check("stop_done", 32'(done), 1);
    check("stop_count", 32'(sym_count), 21);
    check("stop_accepts", accept_cnt, 21);

    // Reset mid-run, then a seed of zero behaves as 7'h01
    ready_mode = 1;
    start_run(7'($urandom_range(1, 127)), 0, 300);
    repeat (5) @(posedge clk);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (tx_valid) break;
    end
    check("mid_valid_seen", 32'(tx_valid), 1);
    #2 rstn = 1'b0;
    #1;
    check("mr_valid", 32'(tx_valid), 0);
    check("mr_sym", tx_symbol, 0);
    check("mr_bits", 32'(tx_bits), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_count", 32'(sym_count), 0);
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    ready_mode = 0;
    start_run(7'h00, 1, 1);
    @(posedge clk);
    #1;
    check("z_valid", 32'(tx_valid), 1);
    check("z_bits", 32'(tx_bits), 0);
    check("z_sym", tx_symbol, -84);
    wait_done("z_done");
    check("z_count", 32'(sym_count), 1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pam4_prbs_tx_mapper.md
# pam4_prbs_tx_mapper

- Transmit-side PAM4 symbol source for the SERDES simulation chain; the transmitter counterpart of the Rx decision slicer.
- Generates a PRBS-7 bit stream, packs 2 bits per symbol and maps each symbol to one of four signed levels (±SYMBOL_SEPERATION/2, ±3·SYMBOL_SEPERATION/2).
- Delivers symbols to the channel/pulse-response model over a valid/ready handshake, and exposes the raw 2-bit symbol for BER checking against the Rx decisions.

## Interface
- SIGNAL_RESOLUTION, 8: signed width of `tx_symbol`.
- SYMBOL_SEPERATION, 56: level spacing. Must be even, and 3·SYMBOL_SEPERATION/2 must fit in SIGNAL_RESOLUTION signed.
- COUNT_WIDTH, 16: width of `num_symbols` and `sym_count`.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous assert, active-low.
- start  in  1  single-cycle pulse; begins a run. Honoured only in IDLE or DONE.
- stop  in  1  single-cycle pulse; ends a continuous or counted run early.
- seed  in  7  PRBS-7 seed, sampled on `start`. Zero is replaced by 7'h01.
- num_symbols  in  COUNT_WIDTH  run length, sampled on `start`. 0 means continuous.
- tx_ready  in  1  downstream accepts the current symbol.
- tx_valid  out  1  `tx_symbol`/`tx_bits` valid.
- tx_symbol  out  SIGNAL_RESOLUTION signed  mapped level.
- tx_bits  out  2  raw symbol {first bit, second bit}.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- sym_count  out  COUNT_WIDTH  symbols accepted (handshakes) in the current run. Saturates at all-ones.

## Operation
- LFSR: Fibonacci PRBS-7, x^7+x^6+1.
  - Per step: b = lfsr[6]^lfsr[5]; lfsr <= {lfsr[5:0], b}.
  - Each symbol takes two steps in one cycle; b1 is the first step, and tx_bits = {b1, b2}.
- Level map, natural binary: 00 → -3S/2, 01 → -S/2, 10 → +S/2, 11 → +3S/2 (S = SYMBOL_SEPERATION).
- States: IDLE (reset), RUN, DRAIN, DONE.
  - IDLE/DONE + start → RUN. In the same edge: lfsr ← seed (0 → 01), remaining ← num_symbols, sym_count ← 0. `done` clears.
  - RUN: the output register loads a new symbol whenever (!tx_valid || tx_ready) and the run is not exhausted. LFSR advances only on a load.
  - RUN → DRAIN when the last symbol is loaded (remaining hits 0 on a counted run), or on `stop`. After this point no further loads occur.
  - DRAIN → DONE when the held symbol is accepted (tx_valid && tx_ready). If tx_valid is already 0, the transition happens the next cycle.
  - DONE holds `done` high until `start`.
- Handshake rules:
  - `tx_symbol`/`tx_bits` are stable while tx_valid && !tx_ready.
  - `tx_valid` never drops without an accept, except on reset.
- Simultaneous events:
  - `start` in RUN/DRAIN is ignored.
  - `stop` in IDLE/DONE is ignored.
  - `start` and `stop` together in IDLE: `start` wins; `stop` is ignored.
  - `stop` in the same cycle as a load: that symbol still loads and must be accepted.
- `sym_count` increments on every handshake.

## Timing
- Reset values: tx_valid 0, tx_symbol 0, tx_bits 0, busy 0, done 0, sym_count 0, lfsr 7'h01, state IDLE.
- `start` sampled at edge N → `tx_valid` high from cycle N+2 carrying symbol 0.
- Throughput: 1 symbol/cycle while tx_ready = 1.
- Counted run with tx_ready held at 1: `done` asserts 1 cycle after the last handshake.
- Reset mid-run clears everything asynchronously. No symbol is replayed after reset.

## Configuration
- `PAM4_GRAY_CODING_EN` defined: Gray map 00 → -3S/2, 01 → -S/2, 11 → +S/2, 10 → +3S/2.
  - `tx_bits` stays the pre-mapping PRBS bits.
- Undefined: natural binary map as in Operation.

## Test plan
- Reset then idle for 10 cycles → tx_valid = 0, busy = 0, done = 0, all outputs 0.
- seed = 7'h7F, num_symbols = 4, tx_ready = 1, binary map → tx_bits 00, 00, 00, 10; tx_symbol -84, -84, -84, +28; first valid 2 cycles after `start`; `done` asserts; sym_count = 4.
- Same stimulus with `PAM4_GRAY_CODING_EN` defined → 4th tx_symbol = +84; tx_bits unchanged.
- Backpressure: tx_ready low for 5 cycles mid-run → tx_symbol/tx_bits frozen, LFSR not advanced, sequence continues with no gap or duplicate.
- num_symbols = 0, `stop` pulsed after 20 accepts while tx_ready = 0 → held symbol stays valid until accepted, then DONE; sym_count = 21.
- Reset asserted mid-run with tx_valid = 1 → outputs cleared immediately. A subsequent `start` with seed = 0 uses 7'h01: first symbol tx_bits 00, tx_symbol -84.
